// File: rtl/vga_pixel2letter.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel2letter
// Purpose  : Recovers a 5-bit letter code from a sampled 16-segment glyph.
//            Per-segment colour samples arrive one per beat. Each segment is
//            classified lit/unlit against the theme background, and the
//            resulting 16-bit lit mask is decoded to a letter code. The
//            result is presented on a valid/ready output.
// Ports    : clk, rst_n              - clock, async active-low reset
//            theme[1:0]              - background select, latched per glyph
//            seg_valid/seg_ready     - beat handshake
//            seg_idx[3:0]            - segment index of the beat
//            seg_color[11:0]         - sampled RGB444 colour of the segment
//            seg_last                - final beat of the glyph
//            letter_valid/ready      - result handshake
//            letter[LETTER_W-1:0]    - decoded code (all-ones when unknown)
//            blank                   - glyph had no lit segments
//            err                     - unknown pattern or incomplete glyph
//            err_cnt[ERRCNT_W-1:0]   - saturating count of delivered errors
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel2letter #(
  parameter int LETTER_W = 5,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          theme,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic [3:0]          seg_idx,
  input  logic [11:0]         seg_color,
  input  logic                seg_last,
  output logic                letter_valid,
  input  logic                letter_ready,
  output logic [LETTER_W-1:0] letter,
  output logic                blank,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECODE  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_mask;
  logic [15:0]         r_seen;
  logic [11:0]         r_bg;
  logic [LETTER_W-1:0] r_letter;
  logic                r_blank;
  logic                r_err;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic                w_seg_fire;
  logic                w_out_fire;
  logic [11:0]         w_theme_bg;
  logic [11:0]         w_bg_cur;
  logic [LETTER_W-1:0] w_code;
  logic                w_known;

  assign w_seg_fire = seg_valid && seg_ready;
  assign w_out_fire = letter_valid && letter_ready;

  always_comb begin
    w_theme_bg = 12'h000;
    case (theme)
      2'd1:    w_theme_bg = 12'hfff;
      2'd2:    w_theme_bg = 12'he7d;
      default: w_theme_bg = 12'h000;
    endcase
  end

  // The first beat of a glyph compares against the live theme, since the
  // background register is only being loaded on that same edge.
  assign w_bg_cur = (r_seen == 16'h0000) ? w_theme_bg : r_bg;

  // Segment mask to letter code.
  always_comb begin
    w_code  = '1;
    w_known = 1'b1;
    case (r_mask)
      16'hC3E7: w_code = LETTER_W'(0);
      16'h83FF: w_code = LETTER_W'(1);
      16'h0139: w_code = LETTER_W'(2);
      16'h81F9: w_code = LETTER_W'(4);
      16'h81BD: w_code = LETTER_W'(6);
      16'hE009: w_code = LETTER_W'(8);
      16'hA930: w_code = LETTER_W'(10);
      16'h0138: w_code = LETTER_W'(11);
      16'h8F36: w_code = LETTER_W'(12);
      16'h033F: w_code = LETTER_W'(14);
      16'h83F3: w_code = LETTER_W'(15);
      16'hA3E3: w_code = LETTER_W'(17);
      16'h83ED: w_code = LETTER_W'(18);
      16'hC001: w_code = LETTER_W'(19);
      default: begin
        w_code  = '1;
        w_known = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    seg_ready    = 1'b0;
    letter_valid = 1'b0;
    case (r_state)
      COLLECT: begin
        seg_ready = 1'b1;
        if (seg_valid && seg_last) begin
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        w_state_next = HOLD;
      end
      HOLD: begin
        letter_valid = 1'b1;
        if (letter_ready) begin
          w_state_next = COLLECT;
        end
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  // Glyph collection: lit mask, seen mask and latched background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= 16'h0000;
      r_seen <= 16'h0000;
      r_bg   <= 12'h000;
    end else if (w_out_fire) begin
      r_mask <= 16'h0000;
      r_seen <= 16'h0000;
    end else if (w_seg_fire) begin
      r_mask[seg_idx] <= (seg_color != w_bg_cur);
      r_seen[seg_idx] <= 1'b1;
      if (r_seen == 16'h0000) begin
        r_bg <= w_theme_bg;
      end
    end
  end

  // Result registers; incomplete glyph outranks blank, which outranks unknown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_letter <= '0;
      r_blank  <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == DECODE) begin
      if (r_seen != 16'hffff) begin
        r_letter <= '1;
        r_blank  <= 1'b0;
        r_err    <= 1'b1;
      end else if (r_mask == 16'h0000) begin
        r_letter <= '1;
        r_blank  <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_letter <= w_code;
        r_blank  <= 1'b0;
        r_err    <= !w_known;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_out_fire && r_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign letter  = r_letter;
  assign blank   = r_blank;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel2letter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel2letter
// Purpose  : Directed self-checking bench for vga_pixel2letter. Glyphs are
//            built from a hand-written lit mask, sent one segment per beat,
//            and the decoded result is compared with hand-computed codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel2letter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  theme;
  logic        seg_valid;
  logic        seg_ready;
  logic [3:0]  seg_idx;
  logic [11:0] seg_color;
  logic        seg_last;
  logic        letter_valid;
  logic        letter_ready;
  logic [4:0]  letter;
  logic        blank;
  logic        err;
  logic [7:0]  err_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int lat;

  vga_pixel2letter #(.LETTER_W(5), .ERRCNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .theme        (theme),
    .seg_valid    (seg_valid),
    .seg_ready    (seg_ready),
    .seg_idx      (seg_idx),
    .seg_color    (seg_color),
    .seg_last     (seg_last),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .letter       (letter),
    .blank        (blank),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge and return right after the edge that takes it.
  task automatic send_beat(input logic [1:0] th, input logic [3:0] idx,
                           input logic [11:0] col, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    theme = th; seg_valid = 1'b1; seg_idx = idx; seg_color = col; seg_last = last;
    while (!seg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_accept_timeout", seg_ready, 1);
    @(posedge clk);
  endtask

  // Beats 0..last_idx; theme th on beat 0, th_mid on later beats.
  task automatic send_glyph(input logic [1:0] th, input logic [1:0] th_mid,
                            input logic [15:0] m, input logic [11:0] lit,
                            input logic [11:0] bgc, input int last_idx);
    for (int i = 0; i <= last_idx; i++) begin
      send_beat((i == 0) ? th : th_mid, 4'(i), m[i] ? lit : bgc, (i == last_idx));
    end
    @(negedge clk);
    seg_valid = 1'b0;
    seg_last  = 1'b0;
  endtask

  // Called at the first negedge after the last beat; expects valid one cycle later.
  task automatic wait_result(output int l);
    l = 1;
    while (!letter_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    check("latency", l, 2);
  endtask

  task automatic handshake();
    letter_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    letter_ready = 1'b0;
    check("valid_drop", letter_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; theme = 2'd0; seg_valid = 1'b0; seg_idx = 4'd0;
    seg_color = 12'h000; seg_last = 1'b0; letter_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",   letter_valid, 0);
    check("rst_ready",   seg_ready,    1);
    check("rst_letter",  letter,       0);
    check("rst_blank",   blank,        0);
    check("rst_err",     err,          0);
    check("rst_err_cnt", err_cnt,      0);
    rst_n = 1'b1;

    // A on black background
    send_glyph(2'd0, 2'd0, 16'hC3E7, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("A_letter", letter, 0);
    check("A_blank",  blank,  0);
    check("A_err",    err,    0);
    handshake();

    // T on white background
    send_glyph(2'd1, 2'd1, 16'hC001, 12'h000, 12'hfff, 15);
    wait_result(lat);
    check("T_letter", letter, 19);
    check("T_err",    err,    0);
    handshake();

    // S on theme 2, theme flipped to white mid-glyph must be ignored
    send_glyph(2'd2, 2'd1, 16'h83ED, 12'h8f0, 12'he7d, 15);
    wait_result(lat);
    check("S_letter", letter, 18);
    check("S_err",    err,    0);
    handshake();

    // All segments at background
    send_glyph(2'd0, 2'd0, 16'h0000, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("blank_blank",  blank,  1);
    check("blank_letter", letter, 31);
    check("blank_err",    err,    0);
    handshake();
    check("blank_err_cnt", err_cnt, 0);

    // Only 15 indices seen before seg_last
    send_glyph(2'd0, 2'd0, 16'hC3E7, 12'hfff, 12'h000, 14);
    wait_result(lat);
    check("short_err",    err,    1);
    check("short_letter", letter, 31);
    check("short_blank",  blank,  0);
    handshake();
    check("short_err_cnt", err_cnt, 1);

    // Full but unlisted pattern
    send_glyph(2'd0, 2'd0, 16'hFFFF, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("ffff_err",    err,    1);
    check("ffff_letter", letter, 31);
    handshake();
    check("ffff_err_cnt", err_cnt, 2);

    // C, then stall the result while the next glyph's first beat waits
    send_glyph(2'd0, 2'd0, 16'h0139, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("C_letter", letter, 2);
    theme = 2'd0; seg_valid = 1'b1; seg_idx = 4'd0; seg_color = 12'h000; seg_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ready",  seg_ready,    0);
      check("stall_valid",  letter_valid, 1);
      check("stall_letter", letter,       2);
    end
    handshake();
    send_glyph(2'd0, 2'd0, 16'h0138, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("L_letter", letter, 11);
    check("L_err",    err,    0);
    handshake();

    // Drive the error counter into saturation with one-beat glyphs
    for (int k = 0; k < 300; k++) begin
      send_glyph(2'd0, 2'd0, 16'h0000, 12'hfff, 12'h000, 0);
      wait_result(lat);
      handshake();
    end
    check("sat_err_cnt", err_cnt, 255);

    // Reset while holding a result: valid must drop before any clock edge
    send_glyph(2'd0, 2'd0, 16'h81F9, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("E_letter", letter, 4);
    #1 rst_n = 1'b0;
    #1;
    check("hold_rst_valid",   letter_valid, 0);
    check("hold_rst_err_cnt", err_cnt,      0);
    check("hold_rst_letter",  letter,       0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after 7 beats of a glyph, then a clean K
    for (int i = 0; i < 7; i++) begin
      send_beat(2'd0, 4'(i), 12'hfff, 1'b0);
    end
    @(negedge clk);
    seg_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", seg_ready,    1);
    check("mid_rst_valid", letter_valid, 0);
    check("mid_rst_err",   err,          0);
    check("mid_rst_blank", blank,        0);
    @(negedge clk);
    rst_n = 1'b1;
    send_glyph(2'd0, 2'd0, 16'hA930, 12'hfff, 12'h000, 15);
    wait_result(lat);
    check("K_letter", letter, 10);
    check("K_err",    err,    0);
    check("K_blank",  blank,  0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
